proj_index_sequencer: RTL and testbench
=======================================

# proj_index_sequencer

Parametrised index generator that walks an FM buffer from index 0 to a run-time last index with a configurable stride. It supports single-shot and continuous (wrap-around) modes, downstream valid/ready back-pressure, abort, and a completed-pass counter. It sits between the FM buffer and the sort/read stage of the MinHash datapath and is the next-generation replacement for the free-running FM index counter.

## Interface
Parameters:
- DEPTH, proj_pkg::FM_BUFFER_SIZE, number of entries in one FM buffer (≥ 2)
- IDX_W, $clog2(DEPTH), index width
- STRIDE, 1, index increment per transfer (1 ≤ STRIDE < DEPTH)
- PASS_W, 8, width of the completed-pass counter

Ports:
- in_clk  input  1  clock; all logic on the rising edge
- in_rst  input  1  synchronous, active-high reset
- in_start  input  1  start request; sampled only in IDLE
- in_mode_cont  input  1  sampled with in_start: 0 = single-shot, 1 = continuous
- in_last_idx  input  IDX_W  last allowed index; sampled with in_start, clamped to DEPTH-1
- in_abort  input  1  terminate the current run
- in_ready  input  1  downstream accepts out_index this cycle
- out_index  output  IDX_W  current index
- out_valid  output  1  out_index is valid
- out_last  output  1  out_index is the final index of this pass
- finished_count  output  1  one-cycle pulse after a pass completes
- out_busy  output  1  FSM not in IDLE
- out_pass_cnt  output  PASS_W  completed passes since reset; wraps modulo 2^PASS_W

## Operation
- Reset values: FSM = IDLE, out_index = 0, out_valid = 0, out_last = 0, finished_count = 0, out_busy = 0, out_pass_cnt = 0, latched last index = 0, latched mode = 0. Reset overrides every other input.
- Latched limit: L = min(in_last_idx, DEPTH-1), captured on start.
- FSM states:
  - IDLE: out_valid = 0. When in_start = 1 and in_abort = 0, latch L and the mode, set out_index = 0, and go to RUN.
  - RUN: out_valid = 1. A transfer occurs when out_valid & in_ready.
  - On a transfer, next = out_index + STRIDE, computed in IDX_W+1 bits so it cannot overflow.
- out_last = RUN & (out_index + STRIDE > L), combinational from the registered index.
- Transfer with out_last = 0: out_index ← next.
- Transfer with out_last = 1:
  - out_pass_cnt increments.
  - finished_count pulses on the next cycle.
  - Continuous mode: out_index ← 0 and the FSM stays in RUN.
  - Single-shot mode: out_index ← 0 and the FSM goes to IDLE.
- in_ready = 0 in RUN: out_index, out_valid and out_last hold.
- in_abort = 1 in RUN: next cycle FSM = IDLE and out_index = 0. No finished pulse and no pass increment, even if the same cycle carried a last transfer. In IDLE, in_abort has priority over in_start.
- in_start while in RUN is ignored. Continuous mode exits only via in_abort or in_rst.
- L = 0 gives a one-entry pass: index 0 only, out_last = 1 on every cycle of RUN.

## Timing
- Start latency: in_start at cycle t gives out_valid = 1 with out_index = 0 at t+1.
- Throughput: one index per cycle while in_ready = 1. Continuous mode has no bubble at wrap: index L' (the last stride point) is followed by 0 on the next cycle.
- finished_count is high exactly one cycle, at t+1 after the last transfer at t. out_pass_cnt updates in the same t+1 cycle.
- Single-shot: out_valid falls at t+1 after the last transfer. A new in_start is accepted at t+1 and its first index appears at t+2.
- All outputs are registered except out_last and out_valid, which decode the state and index registers. There is no combinational path from in_ready to any output.

## Test plan
- Reset, single-shot, DEPTH=16, STRIDE=1, in_last_idx=15, in_ready=1 -> out_index 0..15 on consecutive cycles; out_last only at 15; finished_count one pulse the cycle after; out_pass_cnt=1; out_busy=0 after.
- Continuous, in_last_idx=5, STRIDE=2, in_ready=1 -> sequence 0,2,4,0,2,4,… with out_last at 4; finished_count pulses every 3 cycles; after 4 passes out_pass_cnt=4; in_abort -> IDLE, out_index=0, no extra pulse.
- Back-pressure: single-shot, in_ready toggling 1,0,0,1,… -> index holds during stalls; every index 0..15 is transferred exactly once; out_last holds at 15 until accepted.
- Clamp and degenerate cases: in_last_idx above DEPTH-1 (DEPTH=12, IDX_W=4, in_last_idx=15) -> runs 0..11. in_last_idx=0 -> single index 0 with out_last=1, one finished pulse.
- Simultaneous events: abort in the same cycle as a last transfer -> no pulse and no pass increment. in_start+in_abort in IDLE -> stays IDLE. in_start during RUN -> ignored, sequence unchanged.
- Mid-run reset: in_rst at index 7 -> next cycle all outputs at reset values and out_pass_cnt=0. A subsequent in_start restarts from 0.

Source files
------------

// File: rtl/proj_index_sequencer.sv
// Index sequencer: walks an FM buffer from 0 to a latched last index with a fixed stride.
// Supports single-shot and continuous (wrap-around) passes, valid/ready back-pressure,
// abort and a completed-pass counter.
module proj_index_sequencer #(
    // Nominally the FM buffer size; this block keeps its own default so it stays self-contained
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned IDX_W  = $clog2(DEPTH),
    parameter int unsigned STRIDE = 1,
    parameter int unsigned PASS_W = 8
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_start,
    input  logic              in_mode_cont,
    input  logic [IDX_W-1:0]  in_last_idx,
    input  logic              in_abort,
    input  logic              in_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_valid,
    output logic              out_last,
    output logic              finished_count,
    output logic              out_busy,
    output logic [PASS_W-1:0] out_pass_cnt
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [IDX_W-1:0] MaxIdx    = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W:0]   StrideExt = (IDX_W + 1)'(STRIDE);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic                mode_q, mode_d;
    logic                fin_q, fin_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic [IDX_W:0]      next_ext;

    // One extra bit so the stride step can never wrap past the limit unnoticed
    assign next_ext = {1'b0, index_q} + StrideExt;

    assign out_valid      = (state_q == StRun);
    assign out_last       = out_valid && (next_ext > {1'b0, last_q});
    assign out_index      = index_q;
    assign finished_count = fin_q;
    assign out_busy       = (state_q != StIdle);
    assign out_pass_cnt   = pass_q;

    // Next-state: start/latch in idle, advance/wrap/abort in run
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        last_d  = last_q;
        mode_d  = mode_q;
        fin_d   = 1'b0;
        pass_d  = pass_q;
        unique case (state_q)
            StIdle: begin
                // Abort wins over start
                if (in_start && !in_abort) begin
                    state_d = StRun;
                    index_d = '0;
                    last_d  = (in_last_idx > MaxIdx) ? MaxIdx : in_last_idx;
                    mode_d  = in_mode_cont;
                end
            end
            StRun: begin
                if (in_abort) begin
                    // Drops any last transfer in the same cycle: no pulse, no count
                    state_d = StIdle;
                    index_d = '0;
                end else if (in_ready) begin
                    if (out_last) begin
                        pass_d  = pass_q + PASS_W'(1);
                        fin_d   = 1'b1;
                        index_d = '0;
                        if (!mode_q) begin
                            state_d = StIdle;
                        end
                    end else begin
                        index_d = next_ext[IDX_W-1:0];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= StIdle;
            index_q <= '0;
            last_q  <= '0;
            mode_q  <= 1'b0;
            fin_q   <= 1'b0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
            fin_q   <= fin_d;
            pass_q  <= pass_d;
        end
    end

endmodule

// File: tb/tb_proj_index_sequencer.sv
// Directed bench for proj_index_sequencer: three instances share stimulus
// (a: DEPTH 16 stride 1, b: DEPTH 16 stride 2, c: DEPTH 12 stride 1).
module tb_proj_index_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] last_idx = '0;
    logic       abort = 1'b0;
    logic       ready = 1'b1;

    logic [3:0] a_idx, b_idx, c_idx;
    logic       a_valid, b_valid, c_valid;
    logic       a_last, b_last, c_last;
    logic       a_fin, b_fin, c_fin;
    logic       a_busy, b_busy, c_busy;
    logic [7:0] a_pass, b_pass, c_pass;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    proj_index_sequencer #(.DEPTH(16), .STRIDE(1), .PASS_W(8)) u_a (
        .in_clk(clk), .in_rst(rst), .in_start(start), .in_mode_cont(mode),
        .in_last_idx(last_idx), .in_abort(abort), .in_ready(ready),
        .out_index(a_idx), .out_valid(a_valid), .out_last(a_last),
        .finished_count(a_fin), .out_busy(a_busy), .out_pass_cnt(a_pass)
    );

    proj_index_sequencer #(.DEPTH(16), .STRIDE(2), .PASS_W(8)) u_b (
        .in_clk(clk), .in_rst(rst), .in_start(start), .in_mode_cont(mode),
        .in_last_idx(last_idx), .in_abort(abort), .in_ready(ready),
        .out_index(b_idx), .out_valid(b_valid), .out_last(b_last),
        .finished_count(b_fin), .out_busy(b_busy), .out_pass_cnt(b_pass)
    );

    proj_index_sequencer #(.DEPTH(12), .STRIDE(1), .PASS_W(8)) u_c (
        .in_clk(clk), .in_rst(rst), .in_start(start), .in_mode_cont(mode),
        .in_last_idx(last_idx), .in_abort(abort), .in_ready(ready),
        .out_index(c_idx), .out_valid(c_valid), .out_last(c_last),
        .finished_count(c_fin), .out_busy(c_busy), .out_pass_cnt(c_pass)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic start_run(input logic cont, input logic [3:0] lim);
        mode = cont;
        last_idx = lim;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  exp_idx;
        bit  done;

        // Reset values
        rst = 1'b1;
        tick();
        tick();
        check_eq("rst_idx", a_idx, 0);
        check_eq("rst_valid", a_valid, 0);
        check_eq("rst_last", a_last, 0);
        check_eq("rst_fin", a_fin, 0);
        check_eq("rst_busy", a_busy, 0);
        check_eq("rst_pass", a_pass, 0);
        rst = 1'b0;

        // Single-shot full pass on a; c clamps 15 -> 11
        start_run(1'b0, 4'd15);
        for (int i = 0; i < 16; i++) begin
            check_eq("ss_idx", a_idx, i);
            check_eq("ss_valid", a_valid, 1);
            check_eq("ss_last", a_last, (i == 15));
            check_eq("ss_fin_low", a_fin, 0);
            if (i < 12) begin
                check_eq("clamp_idx", c_idx, i);
                check_eq("clamp_last", c_last, (i == 11));
            end
            if (i == 12) begin
                check_eq("clamp_fin", c_fin, 1);
                check_eq("clamp_busy", c_busy, 0);
                check_eq("clamp_pass", c_pass, 1);
            end
            tick();
        end
        check_eq("ss_fin", a_fin, 1);
        check_eq("ss_pass", a_pass, 1);
        check_eq("ss_busy_after", a_busy, 0);
        check_eq("ss_valid_after", a_valid, 0);
        // Restart accepted in the cycle right after the last transfer
        start_run(1'b0, 4'd2);
        check_eq("restart_valid", a_valid, 1);
        check_eq("restart_idx", a_idx, 0);
        check_eq("restart_fin", a_fin, 0);

        // Continuous, stride 2, limit 5 on b: 0,2,4,0,...
        do_reset();
        start_run(1'b1, 4'd5);
        for (int c = 0; c < 12; c++) begin
            check_eq("cont_idx", b_idx, (c % 3) * 2);
            check_eq("cont_last", b_last, (c % 3 == 2));
            check_eq("cont_fin", b_fin, (c > 0 && c % 3 == 0));
            check_eq("cont_pass", b_pass, c / 3);
            tick();
        end
        check_eq("cont_fin4", b_fin, 1);
        check_eq("cont_pass4", b_pass, 4);
        check_eq("cont_wrap_idx", b_idx, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("cont_abort_busy", b_busy, 0);
        check_eq("cont_abort_idx", b_idx, 0);
        check_eq("cont_abort_fin", b_fin, 0);
        check_eq("cont_abort_pass", b_pass, 4);

        // Back-pressure: ready pattern 1,0,0,1,0,0,...
        do_reset();
        start_run(1'b0, 4'd15);
        exp_idx = 0;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            check_eq("bp_idx", a_idx, exp_idx);
            check_eq("bp_valid", a_valid, 1);
            check_eq("bp_last", a_last, (exp_idx == 15));
            ready = (k % 3 == 0);
            tick();
            if (ready) begin
                if (exp_idx == 15) done = 1'b1;
                else exp_idx++;
            end
        end
        ready = 1'b1;
        check_eq("bp_done", done, 1);
        check_eq("bp_fin", a_fin, 1);
        check_eq("bp_pass", a_pass, 1);
        check_eq("bp_busy", a_busy, 0);

        // Limit 0: one-entry pass
        do_reset();
        start_run(1'b0, 4'd0);
        check_eq("l0_idx", a_idx, 0);
        check_eq("l0_valid", a_valid, 1);
        check_eq("l0_last", a_last, 1);
        tick();
        check_eq("l0_fin", a_fin, 1);
        check_eq("l0_pass", a_pass, 1);
        check_eq("l0_busy", a_busy, 0);
        tick();
        check_eq("l0_fin_once", a_fin, 0);
        // Continuous limit 0: last on every cycle, pulse every cycle
        start_run(1'b1, 4'd0);
        for (int c = 0; c < 3; c++) begin
            check_eq("l0c_idx", a_idx, 0);
            check_eq("l0c_last", a_last, 1);
            check_eq("l0c_fin", a_fin, (c > 0));
            check_eq("l0c_pass", a_pass, 1 + c);
            tick();
        end
        check_eq("l0c_pass4", a_pass, 4);
        // Abort together with a last transfer: no count, no pulse
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_last_pass", a_pass, 4);
        check_eq("abort_last_fin", a_fin, 0);
        check_eq("abort_last_busy", a_busy, 0);

        // Start+abort in idle stays idle
        do_reset();
        mode = 1'b0;
        last_idx = 4'd15;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_eq("sa_busy", a_busy, 0);
        check_eq("sa_valid", a_valid, 0);
        // Start during run is ignored
        start_run(1'b0, 4'd7);
        for (int i = 0; i < 8; i++) begin
            check_eq("ign_idx", a_idx, i);
            check_eq("ign_last", a_last, (i == 7));
            if (i == 3) begin
                start = 1'b1;
                last_idx = 4'd2;
                mode = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check_eq("ign_busy", a_busy, 0);
        check_eq("ign_fin", a_fin, 1);
        check_eq("ign_pass", a_pass, 1);
        // Single-shot abort on the last index
        start_run(1'b0, 4'd3);
        tick();
        tick();
        tick();
        check_eq("ssab_idx", a_idx, 3);
        check_eq("ssab_last", a_last, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("ssab_fin", a_fin, 0);
        check_eq("ssab_pass", a_pass, 1);
        check_eq("ssab_busy", a_busy, 0);
        check_eq("ssab_idx0", a_idx, 0);

        // Mid-run reset at index 7 after one completed pass
        do_reset();
        start_run(1'b0, 4'd0);
        tick();
        check_eq("mr_pre_pass", a_pass, 1);
        start_run(1'b0, 4'd15);
        for (int i = 0; i < 7; i++) tick();
        check_eq("mr_idx7", a_idx, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mr_idx", a_idx, 0);
        check_eq("mr_valid", a_valid, 0);
        check_eq("mr_last", a_last, 0);
        check_eq("mr_fin", a_fin, 0);
        check_eq("mr_busy", a_busy, 0);
        check_eq("mr_pass", a_pass, 0);
        start_run(1'b0, 4'd15);
        check_eq("mr_restart_idx", a_idx, 0);
        check_eq("mr_restart_valid", a_valid, 1);
        tick();
        check_eq("mr_restart_idx1", a_idx, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
